// File: rtl/pll_rst_seq.sv
// PLL lock-qualified reset sequencer: holds the core in reset until the PLL
// has been stably locked for LOCK_CYCLES, supports a stretched soft reset,
// generates a divided clock-enable while running and counts lock losses.
module pll_rst_seq #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CEN_DIV     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       rst_out,
    output logic       ready,
    output logic       cen,
    output logic [7:0] lost_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CEN_W  = 4;
    localparam int unsigned LOST_W = 8;

    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CEN_W-1:0]  CEN_LAST  = CEN_W'(CEN_DIV - 1);
    localparam logic [LOST_W-1:0] LOST_MAX  = '1;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_COUNT     = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [CNT_W-1:0]    r_cnt;
    logic [CEN_W-1:0]    r_cen_cnt;
    logic [LOST_W-1:0]   r_lost_cnt;
    logic                r_rst_out;
    logic                r_ready;
    logic                r_cen;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CEN_W-1:0]    w_cen_cnt_nxt;
    logic [LOST_W-1:0]   w_lost_nxt;
    logic [LOST_W-1:0]   w_lost_inc;
    logic                w_run_nxt;

    // Two-flop synchroniser; r_sync2 is the only consumer-visible lock flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, counter and lost-count decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lost_nxt    = r_lost_cnt;
        w_cen_cnt_nxt = '0;
        w_lost_inc    = (r_lost_cnt == LOST_MAX) ? r_lost_cnt
                                                 : r_lost_cnt + LOST_W'(1);
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (r_sync2) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!r_sync2) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!r_sync2) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = w_lost_inc;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Lock loss wins over a simultaneous soft reset request
                if (!r_sync2) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = w_lost_inc;
                end else if (soft_rst) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
        // Enable phase only advances while staying in RUN, so each RUN entry restarts at 0
        if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
            w_cen_cnt_nxt = (r_cen_cnt == CEN_LAST) ? '0 : r_cen_cnt + CEN_W'(1);
        end
        w_run_nxt = (w_state_nxt == S_RUN);
    end

    // State, counters and registered outputs share one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= '0;
            r_cen_cnt  <= '0;
            r_lost_cnt <= '0;
            r_rst_out  <= 1'b1;
            r_ready    <= 1'b0;
            r_cen      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cen_cnt  <= w_cen_cnt_nxt;
            r_lost_cnt <= w_lost_nxt;
            r_rst_out  <= !w_run_nxt;
            r_ready    <= w_run_nxt;
            r_cen      <= w_run_nxt && (w_cen_cnt_nxt == CEN_LAST);
        end
    end

    assign rst_out  = r_rst_out;
    assign ready    = r_ready;
    assign cen      = r_cen;
    assign lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: a cycle-level behavioural model is
// compared against the DUT on every falling edge, and directed scenarios pin
// key timings with hand-computed literal expectations.
module tb_pll_rst_seq;

    localparam int LOCK = 16;
    localparam int HOLD = 8;
    localparam int DIV  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       rst_out;
    logic       ready;
    logic       cen;
    logic [7:0] lost_cnt;

    int n_chk = 0;
    int n_err = 0;
    int e_n;

    pll_rst_seq #(
        .LOCK_CYCLES(LOCK),
        .HOLD_CYCLES(HOLD),
        .CEN_DIV    (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .soft_rst(soft_rst),
        .rst_out (rst_out),
        .ready   (ready),
        .cen     (cen),
        .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release (edge 1 is the first edge with rst low)
    always @(posedge clk or posedge rst) begin
        if (rst) e_n <= 0;
        else     e_n <= e_n + 1;
    end

    // Model: m_rel = -1 waiting for lock, >0 reset cycles still to go, 0 running
    int   m_rel, n_rel;
    bit   m_hold, n_hold;
    int   m_lost, n_lost;
    int   m_age, n_age;
    logic m_s1, m_s2;

    always_comb begin
        n_rel  = m_rel;
        n_hold = m_hold;
        n_lost = m_lost;
        if (m_rel < 0) begin
            if (m_s2) begin
                n_rel  = LOCK;
                n_hold = 1'b0;
            end
        end else if (m_rel > 0) begin
            if (!m_s2) begin
                n_rel = -1;
                if (m_hold) n_lost = (m_lost >= 255) ? 255 : m_lost + 1;
            end else begin
                n_rel = m_rel - 1;
            end
        end else begin
            if (!m_s2) begin
                n_rel  = -1;
                n_lost = (m_lost >= 255) ? 255 : m_lost + 1;
            end else if (soft_rst) begin
                n_rel  = HOLD;
                n_hold = 1'b1;
            end
        end
        n_age = (m_rel == 0 && n_rel == 0) ? m_age + 1 : 0;
    end

    // Model state update
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1   <= 1'b0;
            m_s2   <= 1'b0;
            m_rel  <= -1;
            m_hold <= 1'b0;
            m_lost <= 0;
            m_age  <= 0;
        end else begin
            m_s1   <= locked;
            m_s2   <= m_s1;
            m_rel  <= n_rel;
            m_hold <= n_hold;
            m_lost <= n_lost;
            m_age  <= n_age;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        chk("model_rst_out", int'(rst_out), (m_rel != 0) ? 1 : 0);
        chk("model_ready",   int'(ready),   (m_rel == 0) ? 1 : 0);
        chk("model_cen",     int'(cen),     (m_rel == 0 && (m_age % DIV) == DIV - 1) ? 1 : 0);
        chk("model_lost",    int'(lost_cnt), m_lost);
    end

    task automatic do_reset();
        rst      = 1'b1;
        locked   = 1'b0;
        soft_rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_en(input int n);
        while (e_n < n) @(negedge clk);
    endtask

    task automatic wait_ready(input string name, input int bound);
        int k = 0;
        while (!ready && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk(name, 0, 1);
    endtask

    task automatic wait_rst_out(input string name, input int bound);
        int k = 0;
        while (!rst_out && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!rst_out) chk(name, 0, 1);
    endtask

    // Reset, lock before edge 10, release after edge 28, cen every 4 cycles
    task automatic cold_start(input string tag);
        do_reset();
        chk({tag, "_rst_rst_out"}, int'(rst_out), 1);
        chk({tag, "_rst_ready"},   int'(ready), 0);
        chk({tag, "_rst_lost"},    int'(lost_cnt), 0);
        wait_en(9);
        locked = 1'b1;
        wait_en(27);
        chk({tag, "_e27_rst_out"}, int'(rst_out), 1);
        chk({tag, "_e27_ready"},   int'(ready), 0);
        wait_en(28);
        chk({tag, "_e28_rst_out"}, int'(rst_out), 0);
        chk({tag, "_e28_ready"},   int'(ready), 1);
        chk({tag, "_e28_cen"},     int'(cen), 0);
        wait_en(30);
        chk({tag, "_e30_cen"}, int'(cen), 0);
        wait_en(31);
        chk({tag, "_e31_cen"}, int'(cen), 1);
        wait_en(34);
        chk({tag, "_e34_cen"}, int'(cen), 0);
        wait_en(35);
        chk({tag, "_e35_cen"}, int'(cen), 1);
    endtask

    // Lock-loss events starting and ending in RUN
    task automatic lose_lock(input int n);
        for (int i = 0; i < n; i++) begin
            locked = 1'b1;
            wait_ready("relock_timeout", 40);
            @(negedge clk);
            locked = 1'b0;
            wait_rst_out("loss_timeout", 8);
        end
        locked = 1'b1;
        wait_ready("relock_timeout", 40);
    endtask

    initial begin
        // Cold start
        cold_start("cold");

        // Soft reset in RUN: 8 cycles of reset, no cen, phase restart
        wait_en(40);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            chk("hold_rst_out", int'(rst_out), 1);
            chk("hold_cen", int'(cen), 0);
            @(negedge clk);
        end
        chk("hold_end_e49", e_n, 49);
        chk("hold_end_rst_out", int'(rst_out), 0);
        wait_en(51);
        chk("hold_e51_cen", int'(cen), 0);
        wait_en(52);
        chk("hold_e52_cen", int'(cen), 1);

        // Lock loss coinciding with soft reset: loss wins
        wait_en(60);
        locked = 1'b0;
        wait_en(62);
        chk("loss_e62_rst_out", int'(rst_out), 0);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        chk("loss_e63_rst_out", int'(rst_out), 1);
        chk("loss_e63_lost", int'(lost_cnt), 1);
        repeat (HOLD + 2) @(negedge clk);
        chk("loss_stays_rst", int'(rst_out), 1);
        chk("loss_lost_held", int'(lost_cnt), 1);

        // Lock glitch during COUNT restarts the full count
        do_reset();
        wait_en(9);
        locked = 1'b1;
        wait_en(20);
        locked = 1'b0;
        wait_en(23);
        locked = 1'b1;
        wait_en(41);
        chk("glitch_e41_rst_out", int'(rst_out), 1);
        wait_en(42);
        chk("glitch_e42_rst_out", int'(rst_out), 0);
        chk("glitch_lost", int'(lost_cnt), 0);

        // Saturation of the lock-loss counter
        lose_lock(300);
        chk("sat_lost_255", int'(lost_cnt), 255);
        lose_lock(1);
        chk("sat_lost_hold", int'(lost_cnt), 255);

        // Asynchronous reset mid-RUN with lost_cnt at 5
        do_reset();
        lose_lock(5);
        chk("async_pre_lost", int'(lost_cnt), 5);
        begin
            int k = 0;
            while (!cen && k < 2 * DIV) begin
                @(negedge clk);
                k++;
            end
            chk("async_pre_cen", int'(cen), 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", int'(rst_out), 1);
        chk("async_ready", int'(ready), 0);
        chk("async_cen", int'(cen), 0);
        chk("async_lost", int'(lost_cnt), 0);
        cold_start("after_async");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: consecutive cycles of synchronised lock required before reset release; legal range 2..65535.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: soft-reset stretch length in cycles; legal range 1..255.
REQ-003 SHALL have parameter CEN_DIV, default 4: clock-enable division ratio; legal range 2..16.
REQ-004 SHALL have port clk, input, 1 bit: PLL output clock (outclk_0 of the 25 MHz PLL); the only clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port locked, input, 1 bit: PLL lock flag, asynchronous to clk.
REQ-007 SHALL have port soft_rst, input, 1 bit: synchronous single-cycle soft-reset request.
REQ-008 SHALL have port rst_out, output, 1 bit: registered active-high core reset.
REQ-009 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port cen, output, 1 bit: clock-enable pulse, one cycle wide.
REQ-011 SHALL have port lost_cnt, output, 8 bits: count of lock-loss events, saturating.

Function
REQ-012 SHALL synchronise locked through two flops; locked_s is locked delayed by two clk edges, and no other logic SHALL sample locked directly.
REQ-013 SHALL implement states WAIT_LOCK, COUNT, HOLD and RUN, with a 16-bit cnt register.
REQ-014 WAIT_LOCK: locked_s=1 SHALL move to COUNT with cnt=0; otherwise it SHALL stay in WAIT_LOCK.
REQ-015 COUNT: locked_s=0 SHALL move to WAIT_LOCK (no lost_cnt increment); else cnt==LOCK_CYCLES-1 SHALL move to RUN; else cnt SHALL increment.
REQ-016 RUN: locked_s=0 SHALL move to WAIT_LOCK and increment lost_cnt, saturating at 255; else soft_rst=1 SHALL move to HOLD with cnt=0.
REQ-017 RUN: when locked_s falls and soft_rst=1 in the same cycle, lock loss SHALL take priority (WAIT_LOCK, lost_cnt increments).
REQ-018 HOLD: locked_s=0 SHALL move to WAIT_LOCK and increment lost_cnt; else cnt==HOLD_CYCLES-1 SHALL move to RUN; else cnt SHALL increment.
REQ-019 soft_rst SHALL be ignored in WAIT_LOCK, COUNT and HOLD; a request is not queued.
REQ-020 rst_out SHALL be a flop updated on the same edge as state, equal to (next state != RUN); it SHALL never glitch.
REQ-021 ready SHALL equal NOT rst_out.
REQ-022 cen_cnt (4 bits) SHALL be held at 0 outside RUN and SHALL count 0..CEN_DIV-1 with wrap in RUN.
REQ-023 cen SHALL be high exactly when state==RUN and cen_cnt==CEN_DIV-1; the first pulse SHALL occur in the CEN_DIV-th cycle of RUN.
REQ-024 Lock-release latency SHALL be: locked rising before edge k gives rst_out low after edge k+2+LOCK_CYCLES, provided locked stays high.

Reset
REQ-025 rst=1 SHALL asynchronously force state=WAIT_LOCK, both sync flops=0, cnt=0, cen_cnt=0, lost_cnt=0, rst_out=1, ready=0, cen=0.
REQ-026 Reset SHALL be released synchronously: the first state update SHALL be on the first clk edge with rst=0.
REQ-027 Assertion of rst mid-operation, including in RUN or HOLD, SHALL immediately give the REQ-025 values; lost_cnt SHALL be cleared, not incremented.

Verification
REQ-028 Cold start (LOCK_CYCLES=16, CEN_DIV=4): release rst, raise locked before edge 10 -> rst_out=1 through edge 27, rst_out=0/ready=1 after edge 28, first cen in RUN cycle 4 and then every 4 cycles.
REQ-029 Lock glitch in COUNT: locked low for 3 cycles at cnt=10 -> return to WAIT_LOCK, full recount of 16 after relock, lost_cnt stays 0.
REQ-030 Soft reset (HOLD_CYCLES=8): one-cycle soft_rst in RUN -> rst_out=1 for exactly 8 cycles then 0, cen silent during HOLD, cen phase restarts from 0.
REQ-031 Lock loss in RUN, with soft_rst pulsed in the same cycle locked_s falls -> WAIT_LOCK, rst_out=1 on the next edge, lost_cnt=1.
REQ-032 Saturation: 300 lock-loss events from RUN -> lost_cnt reads 255 and holds.
REQ-033 Async reset mid-RUN (lost_cnt=5): assert rst between edges -> rst_out=1, cen=0, lost_cnt=0 immediately with no clk edge; normal REQ-028 sequence after release.
